// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared types and constants for the FIFO read drainer.
//   drain_state_e : FSM states of the drainer (IDLE, RUN, DRAIN)
//   SKID_DEPTH    : number of entries in the output skid buffer
//   occ_t         : skid buffer occupancy (0..SKID_DEPTH)
package fifo_drain_pkg;

    localparam int unsigned SKID_DEPTH = 2;

    typedef logic [1:0] occ_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } drain_state_e;

endpackage

// File: rtl/fifo_drain_skid.sv
// fifo_drain_skid: 2-entry in-order buffer between the FIFO read port and the output stage.
// Ports:
//   clk       in  clock
//   reset     in  asynchronous active-low reset; discards all entries
//   push      in  write push_data at the tail this edge (caller guarantees occ < 2)
//   push_data in  WIDTH data to enqueue
//   pop       in  drop the head entry this edge (caller guarantees occ > 0)
//   occ       out current number of stored entries
//   head      out head entry, or 0 when empty
module fifo_drain_skid
    import fifo_drain_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output occ_t             occ,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [SKID_DEPTH];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    occ_t             occ_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign occ  = occ_q;
    assign head = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fifo_read_drainer.sv
// fifo_read_drainer: read-side consumer of an async FIFO in the rclk domain. Pops the FIFO
// into a 2-entry skid buffer and presents items over valid/ready, with enable/drain sequencing.
// Ports:
//   rclk        in  read-domain clock
//   reset       in  asynchronous active-low reset
//   en          in  enables popping from the FIFO
//   empty       in  FIFO empty flag (rclk synchronous)
//   rdata       in  FIFO show-ahead head data
//   pop         out pop strobe to the FIFO
//   out_valid   out out_data holds a valid item
//   out_data    out head of the skid buffer (0 when empty)
//   out_ready   in  downstream accepts the item
//   idle        out FSM is in IDLE
//   pop_count   out total pops since reset (wrapping)
//   stall_count out cycles with out_valid && !out_ready (saturating)
// Build option: define FIFO_DRAIN_STATS_EN to build the counters; otherwise they read 0.
module fifo_read_drainer
    import fifo_drain_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic             en,
    input  logic             empty,
    input  logic [WIDTH-1:0] rdata,
    output logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             idle,
    output logic [CNT_W-1:0] pop_count,
    output logic [CNT_W-1:0] stall_count
);

    drain_state_e state_q;
    occ_t         occ;
    occ_t         occ_next;
    logic         deq;

    // pop depends only on registered state/occ and empty; out_ready never reaches it.
    assign pop       = (state_q == RUN) && !empty && (occ < occ_t'(SKID_DEPTH));
    assign out_valid = (occ != '0);
    assign deq       = out_valid && out_ready;
    assign occ_next  = occ + {1'b0, pop} - {1'b0, deq};
    assign idle      = (state_q == IDLE);

    fifo_drain_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (rclk),
        .reset     (reset),
        .push      (pop),
        .push_data (rdata),
        .pop       (deq),
        .occ       (occ),
        .head      (out_data)
    );

    always_ff @(posedge rclk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en) state_q <= RUN;
                end
                RUN: begin
                    // Decision uses current occupancy; a final pop may still land this cycle.
                    if (!en) state_q <= (occ == '0) ? IDLE : DRAIN;
                end
                DRAIN: begin
                    if (en) begin
                        state_q <= RUN;
                    end else if (occ_next == '0) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FIFO_DRAIN_STATS_EN
    logic [CNT_W-1:0] pop_count_q;
    logic [CNT_W-1:0] stall_count_q;

    always_ff @(posedge rclk or negedge reset) begin
        if (!reset) begin
            pop_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            if (pop) begin
                pop_count_q <= pop_count_q + 1'b1;
            end
            if (out_valid && !out_ready && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + 1'b1;
            end
        end
    end

    assign pop_count   = pop_count_q;
    assign stall_count = stall_count_q;
`else
    assign pop_count   = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fifo_read_drainer.sv
// tb_fifo_read_drainer: randomized and directed self-checking bench for fifo_read_drainer.
// A queue-based model of the FIFO source, skid contents, sequencing state and counters is
// compared with every DUT output each cycle, plus literal checks on directed scenarios.
module tb_fifo_read_drainer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;

    logic             rclk = 1'b0;
    logic             reset;
    logic             en;
    logic             empty;
    logic [WIDTH-1:0] rdata;
    logic             pop;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             idle;
    logic [CNT_W-1:0] pop_count;
    logic [CNT_W-1:0] stall_count;

    fifo_read_drainer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .rclk        (rclk),
        .reset       (reset),
        .en          (en),
        .empty       (empty),
        .rdata       (rdata),
        .pop         (pop),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .idle        (idle),
        .pop_count   (pop_count),
        .stall_count (stall_count)
    );

    always #5 rclk = ~rclk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state
    int               m_state;
    logic [WIDTH-1:0] mq[$];
    logic [CNT_W-1:0] m_pc;
    logic [CNT_W-1:0] m_sc;
    logic [WIDTH-1:0] src[$];
    bit               force_empty;

    // Observations
    int               pops_seen;
    logic [WIDTH-1:0] delivered[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CNT_W-1:0] exp_pc();
`ifdef FIFO_DRAIN_STATS_EN
        return m_pc;
`else
        return '0;
`endif
    endfunction

    function automatic logic [CNT_W-1:0] exp_sc();
`ifdef FIFO_DRAIN_STATS_EN
        return m_sc;
`else
        return '0;
`endif
    endfunction

    // Called at a negedge with en/out_ready already set; ends at the next negedge.
    task automatic step();
        logic             e_pop;
        logic             e_valid;
        logic [WIDTH-1:0] e_data;
        int               occ_after;
        empty = force_empty || (src.size() == 0);
        rdata = (src.size() != 0) ? src[0] : WIDTH'($urandom);
        #1;
        e_pop   = (m_state == S_RUN) && !empty && (mq.size() < 2);
        e_valid = (mq.size() != 0);
        e_data  = e_valid ? mq[0] : '0;
        chk("pop", 32'(pop), 32'(e_pop));
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("out_data", 32'(out_data), 32'(e_data));
        chk("idle", 32'(idle), 32'(m_state == S_IDLE));
        chk("pop_count", 32'(pop_count), 32'(exp_pc()));
        chk("stall_count", 32'(stall_count), 32'(exp_sc()));
        if (pop) pops_seen++;
        if (out_valid && out_ready) delivered.push_back(out_data);
        // Advance the model: dequeue before enqueue keeps FIFO order.
        if (e_valid && out_ready) void'(mq.pop_front());
        if (e_pop) begin
            mq.push_back(src.pop_front());
            m_pc = m_pc + 1'b1;
        end
        if (e_valid && !out_ready && (m_sc != '1)) m_sc = m_sc + 1'b1;
        occ_after = mq.size();
        case (m_state)
            S_IDLE:  if (en) m_state = S_RUN;
            S_RUN:   if (!en) m_state = e_valid ? S_DRAIN : S_IDLE;
            S_DRAIN: if (en) m_state = S_RUN;
                     else if (occ_after == 0) m_state = S_IDLE;
            default: m_state = S_IDLE;
        endcase
        @(posedge rclk);
        @(negedge rclk);
    endtask

    // Called at a negedge: pulses reset low across one rising edge.
    task automatic do_reset();
        reset = 1'b0;
        empty = force_empty || (src.size() == 0);
        #1;
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_pop_count", 32'(pop_count), 32'd0);
        chk("rst_stall_count", 32'(stall_count), 32'd0);
        mq.delete();
        m_state = S_IDLE;
        m_pc    = '0;
        m_sc    = '0;
        @(posedge rclk);
        @(negedge rclk);
        reset = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int p0;
        reset       = 1'b0;
        en          = 1'b0;
        out_ready   = 1'b0;
        empty       = 1'b1;
        rdata       = '0;
        force_empty = 1'b0;
        m_state     = S_IDLE;
        m_pc        = '0;
        m_sc        = '0;
        pops_seen   = 0;
        @(negedge rclk);
        do_reset();

        // Streaming 0x11, 0x22, 0x33 with no backpressure.
        src = '{8'h11, 8'h22, 8'h33};
        en = 1'b1;
        out_ready = 1'b1;
        delivered.delete();
        p0 = pops_seen;
        run(6);
        chk("stream_pops", 32'(pops_seen - p0), 32'd3);
        chk("stream_n", 32'(delivered.size()), 32'd3);
        if (delivered.size() == 3) begin
            chk("stream_d0", 32'(delivered[0]), 32'h11);
            chk("stream_d1", 32'(delivered[1]), 32'h22);
            chk("stream_d2", 32'(delivered[2]), 32'h33);
        end
`ifdef FIFO_DRAIN_STATS_EN
        chk("stream_pop_count", 32'(pop_count), 32'd3);
`else
        chk("stream_pop_count", 32'(pop_count), 32'd0);
`endif

        // Backpressure: exactly two pops fill the skid buffer.
        src = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        out_ready = 1'b0;
        p0 = pops_seen;
        run(6);
        chk("bp_pops", 32'(pops_seen - p0), 32'd2);
        #1;
        chk("bp_pop_low", 32'(pop), 32'd0);
        chk("bp_head", 32'(out_data), 32'hA0);
        @(negedge rclk);
        out_ready = 1'b1;
        delivered.delete();
        step();
        out_ready = 1'b0;
        p0 = pops_seen;
        run(2);
        chk("bp_refill_pops", 32'(pops_seen - p0), 32'd1);
        chk("bp_deq_item", 32'(delivered.size() == 1 ? delivered[0] : 8'hFF), 32'hA0);

        // Drain with a full skid buffer.
        en = 1'b0;
        out_ready = 1'b1;
        delivered.delete();
        p0 = pops_seen;
        run(4);
        chk("drain_pops", 32'(pops_seen - p0), 32'd0);
        chk("drain_n", 32'(delivered.size()), 32'd2);
        if (delivered.size() == 2) begin
            chk("drain_d0", 32'(delivered[0]), 32'hA1);
            chk("drain_d1", 32'(delivered[1]), 32'hA2);
        end
        chk("drain_idle", 32'(idle), 32'd1);

        // Empty FIFO while enabled.
        force_empty = 1'b1;
        en = 1'b1;
        run(6);
        chk("empty_idle", 32'(idle), 32'd0);
        chk("empty_valid", 32'(out_valid), 32'd0);
        force_empty = 1'b0;

        // Reset mid-stream with the skid buffer full.
        src = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        out_ready = 1'b0;
        run(4);
        do_reset();
        out_ready = 1'b1;
        delivered.delete();
        run(5);
        chk("post_rst_first", 32'(delivered.size() != 0 ? delivered[0] : 8'hFF), 32'hC2);

        // 17 pops from reset wrap a 4-bit pop counter to 1.
        do_reset();
        src.delete();
        for (int i = 0; i < 17; i++) src.push_back(WIDTH'(i + 8'h40));
        p0 = pops_seen;
        run(22);
        chk("wrap_pops", 32'(pops_seen - p0), 32'd17);
`ifdef FIFO_DRAIN_STATS_EN
        chk("wrap_pop_count", 32'(pop_count), 32'd1);
`else
        chk("wrap_pop_count", 32'(pop_count), 32'd0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) en = ~en;
            out_ready = ($urandom_range(0, 2) != 0);
            if ((src.size() < 4) && ($urandom_range(0, 1) == 1)) src.push_back(WIDTH'($urandom));
            force_empty = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
